// File: rtl/footsies_pkg.sv
// footsies_pkg: shared coordinate width, box type, attacker FSM encoding and winner codes.
package footsies_pkg;
  localparam int COORD_W = 10;
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;
  typedef enum logic [1:0] {IDLE, ARMED, SPENT} atk_state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  // A held attack box can land once; it re-arms only after the box drops.
  function automatic atk_state_t atk_next(atk_state_t s, logic active, logic cand);
    return !active ? IDLE : (cand || s == SPENT) ? SPENT : ARMED;
  endfunction
endpackage

// File: rtl/box_overlap.sv
// box_overlap: strict overlap of two active boxes; touching edges and degenerate boxes never overlap.
module box_overlap
  import footsies_pkg::*;
(
  input  box_t a,
  input  logic a_active,
  input  box_t b,
  input  logic b_active,
  output logic hit
);
  assign hit = a_active && b_active &&
               a.x1 < a.x2 && a.y1 < a.y2 && b.x1 < b.x2 && b.y1 < b.y2 &&
               a.x1 < b.x2 && b.x1 < a.x2 && a.y1 < b.y2 && b.y1 < a.y2;
endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: per-frame hit arbitration, hitstun timers and round scoring.
// Define HIT_RESOLVER_TRADE_EN to let simultaneous hits both register instead of clashing.
module hit_resolver
  import footsies_pkg::*;
#(
  parameter int HITSTUN_FRAMES = 20,
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               round_reset,
  input  logic [COORD_W-1:0] p1_hitbox_x1,
  input  logic [COORD_W-1:0] p1_hitbox_x2,
  input  logic [COORD_W-1:0] p1_hitbox_y1,
  input  logic [COORD_W-1:0] p1_hitbox_y2,
  input  logic               p1_hitbox_active,
  input  logic [COORD_W-1:0] p1_hurtbox_x1,
  input  logic [COORD_W-1:0] p1_hurtbox_x2,
  input  logic [COORD_W-1:0] p1_hurtbox_y1,
  input  logic [COORD_W-1:0] p1_hurtbox_y2,
  input  logic               p1_hurtbox_active,
  input  logic [COORD_W-1:0] p2_hitbox_x1,
  input  logic [COORD_W-1:0] p2_hitbox_x2,
  input  logic [COORD_W-1:0] p2_hitbox_y1,
  input  logic [COORD_W-1:0] p2_hitbox_y2,
  input  logic               p2_hitbox_active,
  input  logic [COORD_W-1:0] p2_hurtbox_x1,
  input  logic [COORD_W-1:0] p2_hurtbox_x2,
  input  logic [COORD_W-1:0] p2_hurtbox_y1,
  input  logic [COORD_W-1:0] p2_hurtbox_y2,
  input  logic               p2_hurtbox_active,
  output logic               p1_hit,
  output logic               p2_hit,
  output logic               trade,
  output logic               p1_stunned,
  output logic               p2_stunned,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               round_over,
  output logic [1:0]         winner
);
  localparam logic [7:0]         STUN = 8'(HITSTUN_FRAMES);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  box_t p1_hb, p1_ub, p2_hb, p2_ub;
  logic c12, c21, v12, v21, g12, g21;
  atk_state_t s1, s2;
  logic [7:0] stun1, stun2, ns1, ns2;
  logic [SCORE_W-1:0] n1, n2;
  assign p1_hb = {p1_hitbox_x1, p1_hitbox_x2, p1_hitbox_y1, p1_hitbox_y2};
  assign p1_ub = {p1_hurtbox_x1, p1_hurtbox_x2, p1_hurtbox_y1, p1_hurtbox_y2};
  assign p2_hb = {p2_hitbox_x1, p2_hitbox_x2, p2_hitbox_y1, p2_hitbox_y2};
  assign p2_ub = {p2_hurtbox_x1, p2_hurtbox_x2, p2_hurtbox_y1, p2_hurtbox_y2};
  box_overlap u_c12 (.a(p1_hb), .a_active(p1_hitbox_active), .b(p2_ub), .b_active(p2_hurtbox_active), .hit(c12));
  box_overlap u_c21 (.a(p2_hb), .a_active(p2_hitbox_active), .b(p1_ub), .b_active(p1_hurtbox_active), .hit(c21));
  assign v12 = c12 && s1 != SPENT && stun2 == '0 && !round_over;
  assign v21 = c21 && s2 != SPENT && stun1 == '0 && !round_over;
`ifdef HIT_RESOLVER_TRADE_EN
  assign g12 = v12;
  assign g21 = v21;
`else
  assign g12 = v12 && !v21;
  assign g21 = v21 && !v12;
`endif
  assign n1  = g12 && !(&p1_score) ? p1_score + 1'b1 : p1_score;
  assign n2  = g21 && !(&p2_score) ? p2_score + 1'b1 : p2_score;
  assign ns1 = g21 ? STUN : stun1 != '0 ? stun1 - 1'b1 : stun1;
  assign ns2 = g12 ? STUN : stun2 != '0 ? stun2 - 1'b1 : stun2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || round_reset) begin
      s1         <= IDLE;
      s2         <= IDLE;
      stun1      <= '0;
      stun2      <= '0;
      p1_hit     <= 1'b0;
      p2_hit     <= 1'b0;
      trade      <= 1'b0;
      p1_stunned <= 1'b0;
      p2_stunned <= 1'b0;
      p1_score   <= '0;
      p2_score   <= '0;
      round_over <= 1'b0;
      winner     <= WIN_NONE;
    end else begin
      p1_hit <= frame_tick && g21;
      p2_hit <= frame_tick && g12;
      trade  <= frame_tick && v12 && v21;
      if (frame_tick) begin
        s1         <= atk_next(s1, p1_hitbox_active, c12);
        s2         <= atk_next(s2, p2_hitbox_active, c21);
        stun1      <= ns1;
        stun2      <= ns2;
        p1_stunned <= ns1 != '0;
        p2_stunned <= ns2 != '0;
        p1_score   <= n1;
        p2_score   <= n2;
        if (!round_over && (n1 == WIN || n2 == WIN)) begin
          round_over <= 1'b1;
          winner     <= n1 == WIN && n2 == WIN ? WIN_DRAW : n1 == WIN ? WIN_P1 : WIN_P2;
        end
      end
    end
  end
endmodule
